// File: rtl/pwm_demodulator.sv
// pwm_demodulator: recovers per-frame high-sample counts from a serial PWM line
//   clk        system clock, shared with the modulator
//   rst_n      asynchronous active-low reset
//   pwm_in     PWM line, possibly asynchronous to clk
//   bit_length frame exponent, frame length N = 2^bit_length (clamped to 1..DATA_W)
//   data_out   high-sample count of the last complete frame (0..N)
//   data_valid one-cycle strobe marking a new data_out
//   locked     frame alignment established, cleared only by reset
//   sync_err   one-cycle strobe for a rising edge off the frame boundary
module pwm_demodulator #(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pwm_in,
  input  logic [5:0]        bit_length,
  output logic [DATA_W:0]   data_out,
  output logic              data_valid,
  output logic              locked,
  output logic              sync_err
);
  typedef enum logic {UNLOCKED, LOCKED} state_t;
  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   s, s_prev, rise;
  logic [5:0]             l, n_lat;
  logic [DATA_W-1:0]      phase, last_p;
  logic [DATA_W:0]        high_cnt;
  assign s      = sync[SYNC_STAGES-1];
  assign rise   = s & ~s_prev;
  assign l      = bit_length == 6'd0 ? 6'd1 : bit_length > 6'(DATA_W) ? 6'(DATA_W) : bit_length;
  // N-1 as a mask; shifting all ones out entirely gives the full-width frame
  assign last_p = ~({DATA_W{1'b1}} << n_lat);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= UNLOCKED;
      sync       <= '0;
      s_prev     <= 1'b0;
      n_lat      <= '0;
      phase      <= '0;
      high_cnt   <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      locked     <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      sync       <= {sync[SYNC_STAGES-2:0], pwm_in};
      s_prev     <= s;
      data_valid <= 1'b0;
      sync_err   <= 1'b0;
      if (state == UNLOCKED) begin
        if (rise) begin
          phase    <= DATA_W'(1);
          high_cnt <= (DATA_W+1)'(1);
          n_lat    <= l;
          locked   <= 1'b1;
          state    <= LOCKED;
        end
      end else if (rise && phase != '0) begin
        // realign: the edge sample becomes phase 0 of a fresh frame
        sync_err <= 1'b1;
        phase    <= DATA_W'(1);
        high_cnt <= (DATA_W+1)'(1);
        n_lat    <= l;
      end else if (phase == last_p) begin
        data_out   <= high_cnt + (DATA_W+1)'(s);
        data_valid <= 1'b1;
        phase      <= '0;
        high_cnt   <= '0;
        n_lat      <= l;
      end else begin
        high_cnt <= high_cnt + (DATA_W+1)'(s);
        phase    <= phase + DATA_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_pwm_demodulator.sv
// tb_pwm_demodulator: scoreboard bench driving PWM frames and checking recovered counts
module tb_pwm_demodulator;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pwm_in = 1'b0;
  logic [5:0]  bit_length = 6'd4;
  logic [16:0] data_out;
  logic        data_valid, locked, sync_err;
  int          total = 0;
  int          bad = 0;
  int          err_cnt = 0;
  bit          chk = 1'b0;
  int          q[$];
  int          part[5] = '{1, 1, 0, 0, 0};
  always #5 clk = ~clk;
  pwm_demodulator dut (
    .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in), .bit_length(bit_length),
    .data_out(data_out), .data_valid(data_valid), .locked(locked), .sync_err(sync_err)
  );
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (sync_err) err_cnt++;
    if (data_valid && chk) begin
      if (q.size() == 0) check("spurious data_valid data_out", int'(data_out), -1);
      else check("data_out", int'(data_out), q.pop_front());
    end
  end
  task automatic drive(input logic v);
    @(posedge clk);
    #1 pwm_in = v;
  endtask
  // one frame of len pin samples with the first `high` samples high;
  // bl >= 0 changes bit_length mid-frame so it applies from the next frame
  task automatic frame(input int len, input int high, input int bl = -1);
    q.push_back(high);
    for (int i = 0; i < len; i++) begin
      drive(i < high);
      if (bl >= 0 && i == len / 2) bit_length = 6'(bl);
    end
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset data_out", int'(data_out), 0);
    check("reset data_valid", int'(data_valid), 0);
    check("reset locked", int'(locked), 0);
    check("reset sync_err", int'(sync_err), 0);
    rst_n = 1'b1;
    chk = 1'b1;
    repeat (4) drive(1'b0);
    check("idle locked", int'(locked), 0);
    frame(16, 7);
    repeat (5) drive(1'b1);
    check("frame before reset emitted", q.size(), 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    pwm_in = 1'b0;
    #1;
    check("midreset data_out", int'(data_out), 0);
    check("midreset data_valid", int'(data_valid), 0);
    check("midreset locked", int'(locked), 0);
    check("midreset sync_err", int'(sync_err), 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (4) drive(1'b0);
    check("post-reset locked", int'(locked), 0);
    frame(16, 5);
    frame(16, 9);
    frame(16, 1);
    check("basic locked", int'(locked), 1);
    frame(16, 0);
    frame(16, 16);
    frame(16, 3);
    check("extremes locked", int'(locked), 1);
    check("no sync_err before misalign", err_cnt, 0);
    frame(16, 6, 2);
    frame(4, 2);
    frame(4, 3);
    frame(4, 1, 3);
    frame(8, 3);
    foreach (part[i]) drive(part[i] != 0);
    frame(8, 4);
    frame(8, 2, 0);
    repeat (4) frame(2, 1);
    for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge clk);
    check("scoreboard drained", q.size(), 0);
    chk = 1'b0;
    check("sync_err pulses", err_cnt, 1);
    check("final locked", int'(locked), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
